// File: rtl/cpu_sram_pkg.sv
// Shared constants and types for the code-SRAM arbiter slice.
// The 1024 x 32 code SRAM is split into two 512-word banks by word address bit 9 (byte addr[11]).
package cpu_sram_pkg;

  localparam int         SRAM_AW       = 10;
  localparam int         SRAM_DEPTH    = 1024;
  localparam logic [3:0] SRAM_WEN_IDLE = 4'hF;

  // Requester indices into the request/grant vectors
  localparam int PORT_IF = 0;  // instruction fetch, read-only
  localparam int PORT_D  = 1;  // loader/debug data bus

  // Power-up sequencing states (only used when the init sweep is built in)
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cpu_sram_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational same-cycle grant.
// rr_last remembers the most recent winner; on a tie the other port wins.
module rr_arb2
  import cpu_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_last;

  // Grant the sole requester, or the port that did not win last time on a tie
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Track the last winner; reset to the data port so fetch wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (|gnt) begin
      rr_last <= gnt[PORT_D];
    end
  end

endmodule

// File: rtl/cpu_sram_arb.sv
// Arbiter/sequencer sharing the single-port code SRAM between instruction
// fetch (port 0, read-only) and the loader/debug bus (port 1, read/write).
// Optional build macro CPU_SRAM_ARB_INIT_EN adds a power-up sweep that fills
// every word with INIT_VAL before any requester is granted.
module cpu_sram_arb
  import cpu_sram_pkg::*;
#(
  parameter int            AW       = SRAM_AW,
  parameter int            DW       = 32,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          sram_cen,
  output logic [3:0]    sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout,
  output logic          init_done
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic [1:0]    rd_grant;
  logic [1:0]    rd_owner;
  logic          wr_access;
  logic          init_busy;
  logic [AW-1:0] init_addr;
  logic [AW-1:0] gnt_addr;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  assign req = {p1_req, p0_req};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (init_done),
    .req   (req),
    .gnt   (gnt)
  );

  assign p0_gnt = gnt[PORT_IF];
  assign p1_gnt = gnt[PORT_D];

  // A granted write with no byte enables is accepted but never touches the SRAM
  assign rd_grant  = {gnt[PORT_D] & ~p1_we, gnt[PORT_IF]};
  assign wr_access = gnt[PORT_D] & p1_we & (|p1_be);
  assign gnt_addr  = gnt[PORT_D] ? p1_addr : p0_addr;

`ifdef CPU_SRAM_ARB_INIT_EN
  arb_state_t    state;
  logic [AW-1:0] init_cnt;

  // Sweep every word once after reset, then hand the SRAM to the requesters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == AW'(SRAM_DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  assign init_busy = (state == INIT);
  assign init_addr = init_cnt;
  assign init_done = (state == RUN);
`else
  assign init_busy = 1'b0;
  assign init_addr = '0;
  assign init_done = 1'b1;
`endif

  // SRAM command: init sweep, granted read, granted write, else idle with addr/din held
  always_comb begin
    sram_cen  = 1'b1;
    sram_wen  = SRAM_WEN_IDLE;
    sram_addr = addr_q;
    sram_din  = din_q;
    if (init_busy) begin
      sram_cen  = 1'b0;
      sram_wen  = 4'h0;
      sram_addr = init_addr;
      sram_din  = INIT_VAL;
    end else if (|rd_grant) begin
      sram_cen  = 1'b0;
      sram_addr = gnt_addr;
    end else if (wr_access) begin
      sram_cen  = 1'b0;
      sram_wen  = ~p1_be;
      sram_addr = p1_addr;
      sram_din  = p1_wdata;
    end
  end

  // Hold the last driven address/data and remember which port owns next cycle's read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      din_q    <= '0;
      rd_owner <= 2'b00;
    end else begin
      addr_q   <= sram_addr;
      din_q    <= sram_din;
      rd_owner <= rd_grant;
    end
  end

  // Read data is steered only to the port that issued the read; the other sees zero
  assign p0_rvalid = rd_owner[PORT_IF];
  assign p1_rvalid = rd_owner[PORT_D];
  assign p0_rdata  = rd_owner[PORT_IF] ? sram_dout : '0;
  assign p1_rdata  = rd_owner[PORT_D]  ? sram_dout : '0;

endmodule

// File: tb/tb_cpu_sram_arb.sv
// Directed, scoreboarded bench for cpu_sram_arb with a behavioural 1024 x 32 SRAM.
// Honours CPU_SRAM_ARB_INIT_EN for the init-sweep scenario.
module tb_cpu_sram_arb;

  localparam logic [31:0] INIT_WORD = 32'h5A5A_A5A5;

  logic        clk;
  logic        rst_n;
  logic        p0_req;
  logic [9:0]  p0_addr;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req;
  logic        p1_we;
  logic [3:0]  p1_be;
  logic [9:0]  p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        sram_cen;
  logic [3:0]  sram_wen;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
  logic        init_done;

  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int total;
  int bad;
  int n;
  int gseen;

  cpu_sram_arb #(.AW(10), .DW(32), .INIT_VAL(INIT_WORD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_addr   (p0_addr),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_be     (p1_be),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM with a backdoor load path
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (!sram_cen) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_wen[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      end
      sram_dout <= mem[sram_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    ref_mem[a] = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Compare read responses one cycle after the grant against the scoreboard
  task automatic resp(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".rv0"}, p0_rvalid, !e.port);
      chk({tag, ".rv1"}, p1_rvalid, e.port);
      chk({tag, ".rd0"}, p0_rdata, e.port ? 32'h0 : e.data);
      chk({tag, ".rd1"}, p1_rdata, e.port ? e.data : 32'h0);
    end else begin
      chk({tag, ".rv0"}, p0_rvalid, 1'b0);
      chk({tag, ".rv1"}, p1_rvalid, 1'b0);
      chk({tag, ".rd0"}, p0_rdata, 32'h0);
      chk({tag, ".rd1"}, p1_rdata, 32'h0);
    end
  endtask

  // One bus cycle: drive, check same-cycle grant/command, then check the response
  task automatic cyc(input logic p0r, input logic [9:0] p0a, input logic p1r,
                     input logic p1w, input logic [3:0] be, input logic [9:0] p1a,
                     input logic [31:0] wd, input logic eg0, input logic eg1,
                     input logic ecen, input logic [3:0] ewen, input string tag);
    p0_req   = p0r;
    p0_addr  = p0a;
    p1_req   = p1r;
    p1_we    = p1w;
    p1_be    = be;
    p1_addr  = p1a;
    p1_wdata = wd;
    #1;
    chk({tag, ".g0"}, p0_gnt, eg0);
    chk({tag, ".g1"}, p1_gnt, eg1);
    chk({tag, ".cen"}, sram_cen, ecen);
    chk({tag, ".wen"}, sram_wen, ewen);
    if (!ecen) chk({tag, ".addr"}, sram_addr, eg1 ? p1a : p0a);
    if (eg1 && p1w && !ecen) chk({tag, ".din"}, sram_din, wd);
    if (eg0) sb.push_back('{port: 1'b0, data: ref_mem[p0a]});
    if (eg1 && !p1w) sb.push_back('{port: 1'b1, data: ref_mem[p1a]});
    if (eg1 && p1w) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[p1a][b*8 +: 8] = wd[b*8 +: 8];
    end
    @(posedge clk); #1;
    resp(tag);
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    p0_req = 1'b0; p0_addr = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_be = '0; p1_addr = '0; p1_wdata = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst.g0", p0_gnt, 1'b0);
    chk("rst.g1", p1_gnt, 1'b0);
    chk("rst.rv0", p0_rvalid, 1'b0);
    chk("rst.rv1", p1_rvalid, 1'b0);
    chk("rst.rd0", p0_rdata, 32'h0);
    chk("rst.rd1", p1_rdata, 32'h0);
`ifdef CPU_SRAM_ARB_INIT_EN
    chk("rst.init_done", init_done, 1'b0);
`else
    chk("rst.init_done", init_done, 1'b1);
    chk("rst.cen", sram_cen, 1'b1);
    chk("rst.wen", sram_wen, 4'hF);
    chk("rst.addr", sram_addr, 10'h0);
    chk("rst.din", sram_din, 32'h0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef CPU_SRAM_ARB_INIT_EN
    // Init sweep: requests held, no grant until every word is written
    for (int i = 0; i < 1024; i++) ref_mem[i] = INIT_WORD;
    p0_req = 1'b1; p0_addr = 10'h000;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h3FF;
    n = 1; gseen = 0;
    while (!init_done && n < 1100) begin
      if (p0_gnt || p1_gnt) gseen++;
      @(posedge clk); #1;
      n++;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    chk("t6.cycles", n, 1024);
    chk("t6.nogrant", gseen, 0);
    chk("t6.done", init_done, 1'b1);
    cyc(1'b1, 10'h000, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, "t6.lo");
    cyc(1'b0, 10'h000, 1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, "t6.hi");
`endif

    load(10'h005, 32'h1234_5678);
    load(10'h006, 32'h6666_0006);
    load(10'h007, 32'h7777_0007);
    load(10'h010, 32'h1010_1010);
    load(10'h200, 32'h1111_1111);

    // Contention: grants alternate starting with fetch, data lands on the right port
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 10'h006, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0,
          (i % 2) == 0, (i % 2) == 1, 1'b0, 4'hF, "t2.tie");
    end

    // Sole fetch read
    cyc(1'b1, 10'h005, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, "t1.p0rd");

    // Byte-masked write then read-back
    cyc(1'b0, 10'h000, 1'b1, 1'b1, 4'b0101, 10'h200, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b0, 4'b1010, "t3.wr");
    cyc(1'b0, 10'h000, 1'b1, 1'b0, 4'h0, 10'h200, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, "t3.rd");

    // Write with no byte enables: granted, no access, memory unchanged
    cyc(1'b0, 10'h000, 1'b1, 1'b1, 4'h0, 10'h200, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 4'hF, "t4.wr0");
    cyc(1'b0, 10'h000, 1'b1, 1'b0, 4'h0, 10'h200, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, "t4.rd");

    // Idle cycle: SRAM deselected, address held from the last access
    #1;
    chk("idle.cen", sram_cen, 1'b1);
    chk("idle.wen", sram_wen, 4'hF);
    chk("idle.addr", sram_addr, 10'h200);
    @(posedge clk); #1;
    resp("idle");

    // Reset right after a fetch grant drops the pending response
    p0_req = 1'b1; p0_addr = 10'h007;
    #1;
    chk("t5.g0", p0_gnt, 1'b1);
    @(negedge clk);
    rst_n  = 1'b0;
    p0_req = 1'b0;
    @(posedge clk); #1;
    chk("t5.rv0", p0_rvalid, 1'b0);
    chk("t5.rd0", p0_rdata, 32'h0);
    chk("t5.rv1", p1_rvalid, 1'b0);
    chk("t5.g1", p1_gnt, 1'b0);
`ifndef CPU_SRAM_ARB_INIT_EN
    chk("t5.cen", sram_cen, 1'b1);
    chk("t5.wen", sram_wen, 4'hF);
    chk("t5.addr", sram_addr, 10'h0);
    chk("t5.din", sram_din, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef CPU_SRAM_ARB_INIT_EN
    n = 1;
    while (!init_done && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5.reinit", n, 1024);
    for (int i = 0; i < 1024; i++) ref_mem[i] = INIT_WORD;
`endif
    cyc(1'b1, 10'h005, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0, 1'b1, 1'b0, 1'b0, 4'hF, "t5.tie1");
    cyc(1'b1, 10'h005, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, "t5.tie2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
